// File: rtl/ring_noc_pkg.sv
// Shared definitions for the bidirectional ring NoC.
// Provides the flit width, header field positions, port indices and a
// helper that halves the hop field of a flit.
package ring_noc_pkg;

  localparam int unsigned PACKET_SIZE = 64;

  localparam int unsigned DIR_BIT = 62;
  localparam int unsigned HOP_MSB = 55;
  localparam int unsigned HOP_LSB = 48;
  localparam int unsigned VC_BIT  = 63;

  localparam int unsigned CW  = 0;
  localparam int unsigned CCW = 1;
  localparam int unsigned PE  = 2;

  typedef logic [PACKET_SIZE-1:0] packet_t;

  // Ring hop: halve the hop field, leave every other bit untouched.
  function automatic packet_t shift_hop(input packet_t p);
    packet_t r;
    r = p;
    r[HOP_MSB:HOP_LSB] = p[HOP_MSB:HOP_LSB] >> 1;
    return r;
  endfunction

endpackage

// File: rtl/ring_vc_input_buffer.sv
// Two-slot virtual-channel input buffer for one router port.
// Ports:
//   clk, reset   clock, synchronous active-low reset
//   polarity     current VC phase; slot[polarity] is external, slot[~polarity] internal
//   si, ri, di   upstream valid, ready (external slot empty), packet
//   req, pkt     internal slot full flag and its packet
//   clr          grant from an output arbiter; empties the internal slot
module ring_vc_input_buffer
  import ring_noc_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    polarity,
  input  logic    si,
  output logic    ri,
  input  packet_t di,
  output logic    req,
  output packet_t pkt,
  input  logic    clr
);

  packet_t [1:0] data;
  logic    [1:0] full;
  logic          ext_idx;
  logic          int_idx;

  assign ext_idx = polarity;
  assign int_idx = ~polarity;

  assign ri  = ~full[ext_idx];
  assign req = full[int_idx];
  assign pkt = data[int_idx];

  // Accept into the external slot and drain the internal slot; they never alias.
  always_ff @(posedge clk) begin
    if (!reset) begin
      full <= '0;
      data <= '0;
    end else begin
      if (si && ri) begin
        data[ext_idx] <= di;
        full[ext_idx] <= 1'b1;
      end
      if (clr) begin
        full[int_idx] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gold_ring_router.sv
// Three-port, two-VC router node for the bidirectional ring.
// Ring flits with hop == 0 eject to the PE, otherwise continue in their
// direction with hop halved; PE flits inject cw/ccw per the header dir bit.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   polarity              VC phase, toggles every cycle
//   cwsi/ccwsi/pesi       input valid      cwri/ccwri/peri  input ready
//   cwdi/ccwdi/pedi       input packet
//   cwso/ccwso/peso       output valid     cwro/ccwro/pero  output ready
//   cwdo/ccwdo/pedo       output packet (registered, one-cycle pulse)
module gold_ring_router
  import ring_noc_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  output logic                   polarity,
  input  logic                   cwsi,
  input  logic                   ccwsi,
  input  logic                   pesi,
  output logic                   cwri,
  output logic                   ccwri,
  output logic                   peri,
  input  logic [PACKET_SIZE-1:0] cwdi,
  input  logic [PACKET_SIZE-1:0] ccwdi,
  input  logic [PACKET_SIZE-1:0] pedi,
  output logic                   cwso,
  output logic                   ccwso,
  output logic                   peso,
  input  logic                   cwro,
  input  logic                   ccwro,
  input  logic                   pero,
  output logic [PACKET_SIZE-1:0] cwdo,
  output logic [PACKET_SIZE-1:0] ccwdo,
  output logic [PACKET_SIZE-1:0] pedo
);

  logic    cw_req, ccw_req, pe_req;
  packet_t cw_pkt, ccw_pkt, pe_pkt;
  logic    cw_clr, ccw_clr, pe_clr;

  ring_vc_input_buffer u_cw_in (
    .clk(clk), .reset(reset), .polarity(polarity),
    .si(cwsi), .ri(cwri), .di(cwdi),
    .req(cw_req), .pkt(cw_pkt), .clr(cw_clr)
  );

  ring_vc_input_buffer u_ccw_in (
    .clk(clk), .reset(reset), .polarity(polarity),
    .si(ccwsi), .ri(ccwri), .di(ccwdi),
    .req(ccw_req), .pkt(ccw_pkt), .clr(ccw_clr)
  );

  ring_vc_input_buffer u_pe_in (
    .clk(clk), .reset(reset), .polarity(polarity),
    .si(pesi), .ri(peri), .di(pedi),
    .req(pe_req), .pkt(pe_pkt), .clr(pe_clr)
  );

  // Route decode on the internal slots.
  logic cw_hop0, ccw_hop0;
  assign cw_hop0  = (cw_pkt[HOP_MSB:HOP_LSB] == 8'h00);
  assign ccw_hop0 = (ccw_pkt[HOP_MSB:HOP_LSB] == 8'h00);

  // Eligibility: full slot, routed here, and downstream ready.
  logic cwo_cw_e, cwo_pe_e, ccwo_ccw_e, ccwo_pe_e, peo_cw_e, peo_ccw_e;
  assign cwo_cw_e   = cw_req  & ~cw_hop0  & cwro;
  assign cwo_pe_e   = pe_req  & ~pe_pkt[DIR_BIT] & cwro;
  assign ccwo_ccw_e = ccw_req & ~ccw_hop0 & ccwro;
  assign ccwo_pe_e  = pe_req  &  pe_pkt[DIR_BIT] & ccwro;
  assign peo_cw_e   = cw_req  &  cw_hop0  & pero;
  assign peo_ccw_e  = ccw_req &  ccw_hop0 & pero;

  // Two-way round robin; ptr = 0 favours the first contender.
  logic cwo_ptr, ccwo_ptr, peo_ptr;
  logic cwo_cw_g, cwo_pe_g, ccwo_ccw_g, ccwo_pe_g, peo_cw_g, peo_ccw_g;
  assign cwo_cw_g   = cwo_cw_e   & (~cwo_ptr  | ~cwo_pe_e);
  assign cwo_pe_g   = cwo_pe_e   & ( cwo_ptr  | ~cwo_cw_e);
  assign ccwo_ccw_g = ccwo_ccw_e & (~ccwo_ptr | ~ccwo_pe_e);
  assign ccwo_pe_g  = ccwo_pe_e  & ( ccwo_ptr | ~ccwo_ccw_e);
  assign peo_cw_g   = peo_cw_e   & (~peo_ptr  | ~peo_ccw_e);
  assign peo_ccw_g  = peo_ccw_e  & ( peo_ptr  | ~peo_cw_e);

  // Routing is unique, so each input sees at most one grant.
  assign cw_clr  = cwo_cw_g   | peo_cw_g;
  assign ccw_clr = ccwo_ccw_g | peo_ccw_g;
  assign pe_clr  = cwo_pe_g   | ccwo_pe_g;

  // Phase, arbiter pointers and output registers.
  // A pointer only moves when both contenders were eligible, so a lone
  // request never steals the favoured position from the loser that is waiting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      polarity <= 1'b0;
      cwo_ptr  <= 1'b0;
      ccwo_ptr <= 1'b0;
      peo_ptr  <= 1'b0;
      cwso     <= 1'b0;
      ccwso    <= 1'b0;
      peso     <= 1'b0;
      cwdo     <= '0;
      ccwdo    <= '0;
      pedo     <= '0;
    end else begin
      polarity <= ~polarity;
      if (cwo_cw_e && cwo_pe_e)     cwo_ptr  <= ~cwo_ptr;
      if (ccwo_ccw_e && ccwo_pe_e)  ccwo_ptr <= ~ccwo_ptr;
      if (peo_cw_e && peo_ccw_e)    peo_ptr  <= ~peo_ptr;
      cwso  <= cwo_cw_g | cwo_pe_g;
      ccwso <= ccwo_ccw_g | ccwo_pe_g;
      peso  <= peo_cw_g | peo_ccw_g;
      cwdo  <= cwo_cw_g   ? shift_hop(cw_pkt)  : (cwo_pe_g  ? shift_hop(pe_pkt) : '0);
      ccwdo <= ccwo_ccw_g ? shift_hop(ccw_pkt) : (ccwo_pe_g ? shift_hop(pe_pkt) : '0);
      pedo  <= peo_cw_g   ? cw_pkt             : (peo_ccw_g ? ccw_pkt           : '0);
    end
  end

endmodule

// File: tb/tb_gold_ring_router.sv
// Directed, table-driven bench for gold_ring_router.
module tb_gold_ring_router;

  logic        clk;
  logic        reset;
  logic        polarity;
  logic        cwsi, ccwsi, pesi;
  logic        cwri, ccwri, peri;
  logic [63:0] cwdi, ccwdi, pedi;
  logic        cwso, ccwso, peso;
  logic        cwro, ccwro, pero;
  logic [63:0] cwdo, ccwdo, pedo;

  int checks = 0;
  int errors = 0;

  gold_ring_router dut (
    .clk(clk), .reset(reset), .polarity(polarity),
    .cwsi(cwsi), .ccwsi(ccwsi), .pesi(pesi),
    .cwri(cwri), .ccwri(ccwri), .peri(peri),
    .cwdi(cwdi), .ccwdi(ccwdi), .pedi(pedi),
    .cwso(cwso), .ccwso(ccwso), .peso(peso),
    .cwro(cwro), .ccwro(ccwro), .pero(pero),
    .cwdo(cwdo), .ccwdo(ccwdo), .pedo(pedo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cwsi, ccwsi, pesi;
    logic [63:0] cwdi, ccwdi, pedi;
    logic        cwso, ccwso, peso;
    logic [63:0] cwdo, ccwdo, pedo;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  // Flit: vc bit, dir, filler, hop, filler, id.
  function automatic logic [63:0] pk(input logic dir, input logic [7:0] hop, input logic [15:0] id);
    return {id[0], dir, 6'h15, hop, 32'hA5A5_0000, id};
  endfunction

  function automatic vec_t vin(input logic cws, input logic [63:0] cwd,
                               input logic ccws, input logic [63:0] ccwd,
                               input logic pes, input logic [63:0] ped);
    vec_t v;
    v.cwsi = cws;  v.cwdi = cwd;
    v.ccwsi = ccws; v.ccwdi = ccwd;
    v.pesi = pes;  v.pedi = ped;
    v.cwso = 1'b0; v.ccwso = 1'b0; v.peso = 1'b0;
    v.cwdo = '0;   v.ccwdo = '0;   v.pedo = '0;
    return v;
  endfunction

  function automatic vec_t idle();
    return vin(1'b0, '0, 1'b0, '0, 1'b0, '0);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cwsi = 1'b0; ccwsi = 1'b0; pesi = 1'b0;
    cwdi = '0; ccwdi = '0; pedi = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_polarity", 64'(polarity), 64'd0);
    chk("rst_cwri", 64'(cwri), 64'd1);
    chk("rst_ccwri", 64'(ccwri), 64'd1);
    chk("rst_peri", 64'(peri), 64'd1);
    chk("rst_so", 64'({cwso, ccwso, peso}), 64'd0);
    chk("rst_cwdo", cwdo, 64'd0);
    chk("rst_ccwdo", ccwdo, 64'd0);
    chk("rst_pedo", pedo, 64'd0);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    cwro = 1'b1; ccwro = 1'b1; pero = 1'b1;

    for (int i = 0; i < NV; i++) vecs[i] = idle();
    // No contention: cw transit, hop 0F -> 07.
    vecs[0] = vin(1'b1, pk(1'b0, 8'h0F, 16'd1), 1'b0, '0, 1'b0, '0);
    vecs[1].cwso = 1'b1; vecs[1].cwdo = pk(1'b0, 8'h07, 16'd1);
    // PE injection cw then ccw.
    vecs[2] = vin(1'b0, '0, 1'b0, '0, 1'b1, pk(1'b0, 8'h05, 16'd2));
    vecs[3] = vin(1'b0, '0, 1'b0, '0, 1'b1, pk(1'b1, 8'h03, 16'd3));
    vecs[3].cwso = 1'b1; vecs[3].cwdo = pk(1'b0, 8'h02, 16'd2);
    vecs[4].ccwso = 1'b1; vecs[4].ccwdo = pk(1'b1, 8'h01, 16'd3);
    // Ejection from cw then ccw, packet unmodified.
    vecs[5] = vin(1'b1, pk(1'b0, 8'h00, 16'd4), 1'b0, '0, 1'b0, '0);
    vecs[6] = vin(1'b0, '0, 1'b1, pk(1'b1, 8'h00, 16'd5), 1'b0, '0);
    vecs[6].peso = 1'b1; vecs[6].pedo = pk(1'b0, 8'h00, 16'd4);
    vecs[7].peso = 1'b1; vecs[7].pedo = pk(1'b1, 8'h00, 16'd5);
    // cw out contention: cw first, PE two cycles later.
    vecs[8] = vin(1'b1, pk(1'b0, 8'h04, 16'd6), 1'b0, '0, 1'b1, pk(1'b0, 8'h09, 16'd7));
    vecs[9].cwso = 1'b1;  vecs[9].cwdo  = pk(1'b0, 8'h02, 16'd6);
    vecs[11].cwso = 1'b1; vecs[11].cwdo = pk(1'b0, 8'h04, 16'd7);
    // Repeat: PE now wins first.
    vecs[12] = vin(1'b1, pk(1'b0, 8'h04, 16'd8), 1'b0, '0, 1'b1, pk(1'b0, 8'h09, 16'd9));
    vecs[13].cwso = 1'b1; vecs[13].cwdo = pk(1'b0, 8'h04, 16'd9);
    vecs[15].cwso = 1'b1; vecs[15].cwdo = pk(1'b0, 8'h02, 16'd8);
    // PE out contention: cw first, then order flips on repeat.
    vecs[16] = vin(1'b1, pk(1'b0, 8'h00, 16'd10), 1'b1, pk(1'b1, 8'h00, 16'd11), 1'b0, '0);
    vecs[17].peso = 1'b1; vecs[17].pedo = pk(1'b0, 8'h00, 16'd10);
    vecs[19].peso = 1'b1; vecs[19].pedo = pk(1'b1, 8'h00, 16'd11);
    vecs[20] = vin(1'b1, pk(1'b0, 8'h00, 16'd12), 1'b1, pk(1'b1, 8'h00, 16'd13), 1'b0, '0);
    vecs[21].peso = 1'b1; vecs[21].pedo = pk(1'b1, 8'h00, 16'd13);
    vecs[23].peso = 1'b1; vecs[23].pedo = pk(1'b0, 8'h00, 16'd12);

    do_reset();

    for (int i = 0; i < NV; i++) begin
      cwsi = vecs[i].cwsi; cwdi = vecs[i].cwdi;
      ccwsi = vecs[i].ccwsi; ccwdi = vecs[i].ccwdi;
      pesi = vecs[i].pesi; pedi = vecs[i].pedi;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_polarity", i), 64'(polarity), 64'((i + 1) % 2));
      chk($sformatf("v%0d_cwso", i), 64'(cwso), 64'(vecs[i].cwso));
      chk($sformatf("v%0d_ccwso", i), 64'(ccwso), 64'(vecs[i].ccwso));
      chk($sformatf("v%0d_peso", i), 64'(peso), 64'(vecs[i].peso));
      if (vecs[i].cwso)  chk($sformatf("v%0d_cwdo", i), cwdo, vecs[i].cwdo);
      if (vecs[i].ccwso) chk($sformatf("v%0d_ccwdo", i), ccwdo, vecs[i].ccwdo);
      if (vecs[i].peso)  chk($sformatf("v%0d_pedo", i), pedo, vecs[i].pedo);
    end
    cwsi = 1'b0; ccwsi = 1'b0; pesi = 1'b0;

    // Fill both cw slots under backpressure, then reset over them.
    cwro = 1'b0;
    cwsi = 1'b1; cwdi = pk(1'b0, 8'h0F, 16'd30);
    @(posedge clk); #1;
    cwdi = pk(1'b0, 8'h0E, 16'd31);
    @(posedge clk); #1;
    cwsi = 1'b0;
    chk("bp_both_full_cwri", 64'(cwri), 64'd0);
    do_reset();

    // Backpressure: packet held while cwro = 0, delivered on its next internal phase.
    cwsi = 1'b1; cwdi = pk(1'b0, 8'h06, 16'd21);
    chk("bp_p0_cwri", 64'(cwri), 64'd1);
    @(posedge clk); #1;
    cwsi = 1'b0;
    chk("bp_p1_polarity", 64'(polarity), 64'd1);
    chk("bp_p1_cwso", 64'(cwso), 64'd0);
    chk("bp_p1_cwri", 64'(cwri), 64'd1);
    @(posedge clk); #1;
    chk("bp_p2_polarity", 64'(polarity), 64'd0);
    chk("bp_p2_cwso", 64'(cwso), 64'd0);
    chk("bp_p2_cwri", 64'(cwri), 64'd0);
    @(posedge clk); #1;
    chk("bp_p3_polarity", 64'(polarity), 64'd1);
    chk("bp_p3_cwso", 64'(cwso), 64'd0);
    cwro = 1'b1;
    @(posedge clk); #1;
    chk("bp_p4_cwso", 64'(cwso), 64'd1);
    chk("bp_p4_cwdo", cwdo, pk(1'b0, 8'h03, 16'd21));
    @(posedge clk); #1;
    chk("bp_p5_cwso", 64'(cwso), 64'd0);
    chk("bp_p5_cwri", 64'(cwri), 64'd1);
    chk("bp_p5_peso", 64'({ccwso, peso}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
